// File: rtl/switch_nxn_arb.sv
// rtl/switch_nxn_arb.sv - NxN crossbar with per-output arbitration and one registered slot per output
// Define SWITCH_RR_ARB_EN for round-robin arbitration; otherwise the lowest requesting input index wins.
module switch_nxn_arb #(
    parameter int WIDTH = 32,
    parameter int PORTS = 4,
    localparam int DEST_W = (PORTS > 2) ? $clog2(PORTS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PORTS-1:0]        io_in_valid,
    output logic [PORTS-1:0]        io_in_ready,
    input  logic [PORTS*WIDTH-1:0]  io_in_bits,
    input  logic [PORTS*DEST_W-1:0] io_in_dest,
    output logic [PORTS-1:0]        io_out_valid,
    input  logic [PORTS-1:0]        io_out_ready,
    output logic [PORTS*WIDTH-1:0]  io_out_bits,
    output logic [PORTS*DEST_W-1:0] io_out_src
);

    localparam logic [DEST_W:0] PORTS_V = (DEST_W + 1)'(PORTS);

    logic [WIDTH-1:0]  in_bits   [PORTS];
    logic [DEST_W-1:0] in_dest   [PORTS];
    logic [PORTS-1:0]  illegal;
    logic [PORTS-1:0]  req       [PORTS];
    logic [PORTS-1:0]  slot_free;
    logic [PORTS-1:0]  gnt_any;
    logic [DEST_W-1:0] gnt_idx   [PORTS];
    logic [WIDTH-1:0]  gnt_bits  [PORTS];
    logic [PORTS-1:0]  slot_valid;
    logic [WIDTH-1:0]  slot_bits [PORTS];
    logic [DEST_W-1:0] slot_src  [PORTS];
    int                idx;
`ifdef SWITCH_RR_ARB_EN
    logic [DEST_W-1:0] rr_ptr    [PORTS];
`endif

    for (genvar g = 0; g < PORTS; g++) begin : g_flat
        assign in_bits[g]                          = io_in_bits[g*WIDTH +: WIDTH];
        assign in_dest[g]                          = io_in_dest[g*DEST_W +: DEST_W];
        assign illegal[g]                          = {1'b0, in_dest[g]} >= PORTS_V;
        assign slot_free[g]                        = !slot_valid[g] || io_out_ready[g];
        assign io_out_bits[g*WIDTH +: WIDTH]       = slot_bits[g];
        assign io_out_src[g*DEST_W +: DEST_W]      = slot_src[g];
    end
    assign io_out_valid = slot_valid;

    // req[o][i]: input i wants output o this cycle
    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < PORTS; i++) begin
                req[o][i] = io_in_valid[i] && (in_dest[i] == DEST_W'(o));
            end
        end
    end

    always_comb begin
        idx = 0;
        for (int o = 0; o < PORTS; o++) begin
            gnt_any[o]  = 1'b0;
            gnt_idx[o]  = '0;
            gnt_bits[o] = '0;
            if (!reset && slot_free[o]) begin
                for (int k = 0; k < PORTS; k++) begin
`ifdef SWITCH_RR_ARB_EN
                    idx = int'(rr_ptr[o]) + k;
                    if (idx >= PORTS) idx = idx - PORTS;
`else
                    idx = k;
`endif
                    if (!gnt_any[o] && req[o][idx]) begin
                        gnt_any[o]  = 1'b1;
                        gnt_idx[o]  = DEST_W'(idx);
                        gnt_bits[o] = in_bits[idx];
                    end
                end
            end
        end
    end

    // Illegal destinations are accepted and dropped so the sender never stalls
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            io_in_ready[i] = !reset && io_in_valid[i] && illegal[i];
            for (int o = 0; o < PORTS; o++) begin
                if (gnt_any[o] && (gnt_idx[o] == DEST_W'(i))) io_in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid <= '0;
            for (int o = 0; o < PORTS; o++) begin
                slot_bits[o] <= '0;
                slot_src[o]  <= '0;
            end
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                if (gnt_any[o]) begin
                    slot_valid[o] <= 1'b1;
                    slot_bits[o]  <= gnt_bits[o];
                    slot_src[o]   <= gnt_idx[o];
                end else if (io_out_ready[o]) begin
                    slot_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef SWITCH_RR_ARB_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int o = 0; o < PORTS; o++) rr_ptr[o] <= '0;
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                if (gnt_any[o]) begin
                    rr_ptr[o] <= (int'(gnt_idx[o]) == PORTS - 1) ? '0 : gnt_idx[o] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_nxn_arb.sv
// tb/tb_switch_nxn_arb.sv - directed scoreboard bench for switch_nxn_arb (4-port and 3-port instances)
module tb_switch_nxn_arb;

`ifdef SWITCH_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_bits, out_bits;
    logic [7:0]   in_dest, out_src;
    logic [2:0]   d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
    logic [23:0]  d3_in_bits, d3_out_bits;
    logic [5:0]   d3_in_dest, d3_out_src;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] bits;
        logic [1:0]  src;
    } ent_t;
    ent_t sbq [4][$];

    always #5 clock = ~clock;

    switch_nxn_arb #(.WIDTH(32), .PORTS(4)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_bits(in_bits), .io_in_dest(in_dest),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_bits(out_bits), .io_out_src(out_src)
    );

    switch_nxn_arb #(.WIDTH(8), .PORTS(3)) dut3 (
        .clock(clock), .reset(reset),
        .io_in_valid(d3_in_valid), .io_in_ready(d3_in_ready),
        .io_in_bits(d3_in_bits), .io_in_dest(d3_in_dest),
        .io_out_valid(d3_out_valid), .io_out_ready(d3_out_ready),
        .io_out_bits(d3_out_bits), .io_out_src(d3_out_src)
    );

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int i, input logic v, input logic [31:0] b, input logic [1:0] d);
        in_valid[i]         = v;
        in_bits[i*32 +: 32] = b;
        in_dest[i*2 +: 2]   = d;
    endtask

    // Pop words consumed this cycle, then push words handshaken this cycle
    task automatic sb_update();
        ent_t e;
        for (int o = 0; o < 4; o++) begin
            if (out_valid[o] && out_ready[o]) begin
                if (sbq[o].size() == 0) begin
                    chk($sformatf("sb_unexpected_out%0d", o), 32'(out_valid[o]), 32'd0);
                end else begin
                    e = sbq[o].pop_front();
                    chk($sformatf("sb_bits_out%0d", o), out_bits[o*32 +: 32], e.bits);
                    chk($sformatf("sb_src_out%0d", o), 32'(out_src[o*2 +: 2]), 32'(e.src));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                e.bits = in_bits[i*32 +: 32];
                e.src  = 2'(i);
                sbq[int'(in_dest[i*2 +: 2])].push_back(e);
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] exp_ready);
        @(negedge clock);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
        sb_update();
        @(posedge clock);
        #1;
    endtask

    initial begin
        in_valid = '0; in_bits = '0; in_dest = '0; out_ready = 4'hF;
        d3_in_valid = '0; d3_in_bits = '0; d3_in_dest = '0; d3_out_ready = 3'b111;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        in_valid = 4'hF;
        @(negedge clock);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_src", 32'(out_src), 32'd0);
        for (int o = 0; o < 4; o++) chk($sformatf("reset_bits%0d", o), out_bits[o*32 +: 32], 32'd0);
        @(posedge clock);
        #1;
        in_valid = '0;
        reset = 1'b0;

        // Straight routing: input i -> output 3-i
        for (int i = 0; i < 4; i++) set_in(i, 1'b1, 32'hA0 + 32'(i), 2'(3 - i));
        step("straight", 4'hF);
        chk("straight_out_valid", 32'(out_valid), 32'hF);
        for (int o = 0; o < 4; o++) begin
            chk($sformatf("straight_bits%0d", o), out_bits[o*32 +: 32], 32'hA0 + 32'(3 - o));
            chk($sformatf("straight_src%0d", o), 32'(out_src[o*2 +: 2]), 32'(3 - o));
        end
        in_valid = '0;
        step("straight_drain", 4'h0);
        chk("straight_idle", 32'(out_valid), 32'h0);

        // Contention on output 1
        for (int i = 0; i < 3; i++) set_in(i, 1'b1, 32'hB0 + 32'(i), 2'd1);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("cont%0d", k), RR ? 4'(4'b0001 << k) : 4'b0001);
            chk($sformatf("cont%0d_src", k), 32'(out_src[3:2]), RR ? 32'(k) : 32'd0);
        end
        in_valid = '0;
        step("cont_drain", 4'h0);
        chk("cont_idle", 32'(out_valid), 32'h0);

        // Back-pressure on output 2
        out_ready = 4'b1011;
        set_in(0, 1'b1, 32'h55, 2'd2);
        step("bp_load", 4'b0001);
        set_in(0, 1'b0, 32'h0, 2'd0);
        set_in(1, 1'b1, 32'h66, 2'd2);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("bp_hold%0d", k), 4'b0000);
            chk($sformatf("bp_hold%0d_bits", k), out_bits[95:64], 32'h55);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid[2]), 32'd1);
        end
        out_ready = 4'hF;
        step("bp_release", 4'b0010);
        chk("bp_next_bits", out_bits[95:64], 32'h66);
        chk("bp_next_src", 32'(out_src[5:4]), 32'd1);
        chk("bp_next_valid", 32'(out_valid[2]), 32'd1);
        in_valid = '0;
        step("bp_drain", 4'h0);

        // Drain and load: continuous stream from input 3 to output 0
        for (int k = 1; k <= 3; k++) begin
            set_in(3, 1'b1, 32'(k), 2'd0);
            step($sformatf("stream%0d", k), 4'b1000);
            chk($sformatf("stream%0d_valid", k), 32'(out_valid[0]), 32'd1);
            chk($sformatf("stream%0d_bits", k), out_bits[31:0], 32'(k));
        end
        in_valid = '0;
        step("stream_drain", 4'h0);
        chk("stream_idle", 32'(out_valid[0]), 32'd0);

        // Reset mid-operation with slots 0 and 2 held
        out_ready = 4'b1010;
        set_in(0, 1'b1, 32'h77, 2'd0);
        set_in(1, 1'b1, 32'h88, 2'd2);
        step("rst_load", 4'b0011);
        chk("rst_pre_valid", 32'(out_valid), 32'b0101);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_bits0", out_bits[31:0], 32'd0);
        chk("rst_bits2", out_bits[95:64], 32'd0);
        for (int o = 0; o < 4; o++) sbq[o].delete();
        reset = 1'b0;
        step("rst_resume", 4'b0011);
        chk("rst_resume_valid", 32'(out_valid), 32'b0101);
        chk("rst_resume_bits0", out_bits[31:0], 32'h77);
        out_ready = 4'hF;
        in_valid = '0;
        step("rst_drain", 4'h0);
        chk("rst_idle", 32'(out_valid), 32'd0);

        // Illegal destination on the 3-port instance
        d3_in_valid = 3'b110;
        d3_in_bits  = {8'h2C, 8'h5A, 8'h00};
        d3_in_dest  = {2'd1, 2'd3, 2'd0};
        @(negedge clock);
        chk("ill_mix_ready", 32'(d3_in_ready), 32'b110);
        @(posedge clock);
        #1;
        chk("ill_mix_valid", 32'(d3_out_valid), 32'b010);
        chk("ill_mix_bits1", 32'(d3_out_bits[15:8]), 32'h2C);
        chk("ill_mix_src1", 32'(d3_out_src[3:2]), 32'd2);
        d3_out_ready = 3'b000;
        d3_in_valid  = 3'b010;
        @(negedge clock);
        chk("ill_only_ready", 32'(d3_in_ready), 32'b010);
        @(posedge clock);
        #1;
        chk("ill_only_valid", 32'(d3_out_valid), 32'b010);
        chk("ill_only_bits1", 32'(d3_out_bits[15:8]), 32'h2C);
        d3_in_valid = '0;

        for (int o = 0; o < 4; o++) chk($sformatf("sb_left_out%0d", o), 32'(sbq[o].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/switch_nxn_arb.md
# switch_nxn_arb

Parametrised N×N crossbar switch with per-input destination select, per-output arbitration, valid/ready handshaking on every port and a one-entry registered stage per output. It generalises the 2×2 select-driven switch in the datapath interconnect. Each input routes to any output, and any number of inputs may target the same output. Contention is resolved by an arbiter per output, and stalled inputs are back-pressured instead of dropped.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- PORTS, 4, number of input and output ports (≥2)
- DEST_W, derived = max(1, clog2(PORTS)), destination index width; not overridable
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_in_valid  input  PORTS  bit i: input i presents a word
- io_in_ready  output  PORTS  bit i: input i word accepted this cycle
- io_in_bits  input  PORTS*WIDTH  input i payload at [i*WIDTH +: WIDTH]
- io_in_dest  input  PORTS*DEST_W  input i destination at [i*DEST_W +: DEST_W]
- io_out_valid  output  PORTS  bit o: output o holds a word
- io_out_ready  input  PORTS  bit o: downstream accepts output o
- io_out_bits  output  PORTS*WIDTH  output o payload
- io_out_src  output  PORTS*DEST_W  index of the input that supplied output o's word

## Operation
- Each output o has one register slot holding valid, bits and src.
- Slot o is free when the slot is not valid, or when io_out_ready[o] is high this cycle.
- Request: input i requests output o when io_in_valid[i] is high and io_in_dest[i]==o.
- Each output with a free slot grants exactly one requester. Non-granted requesters see io_in_ready[i]=0 and must hold valid, bits and dest stable.
- Grant to i: io_in_ready[i]=1. On the next edge the slot loads bits and src=i, and valid=1.
- Free slot with no requester: valid clears if io_out_ready[o] was high. Otherwise the slot holds.
- Illegal destination (io_in_dest[i] ≥ PORTS, possible only when PORTS is not a power of two): io_in_ready[i]=1 and the word is discarded. No output is affected.
- An input never receives more than one grant per cycle, because each input targets exactly one output.
- Distinct destinations never interact. All PORTS transfers may complete in the same cycle.

## Timing
- Reset values: io_out_valid=0, io_out_bits=0, io_out_src=0, all round-robin pointers=0. io_in_ready=0 while reset is high.
- Reset mid-operation discards all held words. The first grant can occur in the first cycle after reset deasserts.
- Latency: 1 cycle from io_in handshake to io_out_valid.
- Throughput: 1 word per output per cycle with continuous io_out_ready.
- io_in_ready is combinational from io_in_valid, io_in_dest, io_out_ready and slot state. No combinational path exists from io_in_* to io_out_*.
- Simultaneous drain and load on one slot in one cycle is legal. The new word replaces the drained one with no bubble.

## Configuration
- SWITCH_RR_ARB_EN defined: round-robin arbitration per output.
  - Pointer p[o] starts at 0.
  - The search runs upward from p[o] and wraps at PORTS.
  - After a grant to i, p[o] = (i+1) mod PORTS.
  - The pointer is unchanged when no grant occurs.
- SWITCH_RR_ARB_EN undefined: fixed priority, lowest input index wins. No pointer state is built.

## Test plan
- Straight routing, PORTS=4, WIDTH=32: inputs 0..3 send 0xA0..0xA3 to dest 3,2,1,0, with all out_ready=1. Required: all io_in_ready=1 in the same cycle. Next cycle out3=0xA0/src0, out2=0xA1/src1, out1=0xA2/src2, out0=0xA3/src3.
- Contention with round-robin: inputs 0,1,2 hold valid to dest 1 for 3 cycles with out_ready[1]=1. Required: grants to inputs 0, 1, 2 in successive cycles. io_out_src[1] sequence 0,1,2. Without SWITCH_RR_ARB_EN, input 0 wins every cycle.
- Back-pressure: input 0 sends 0x55 to dest 2 with out_ready[2]=0 for 4 cycles. Required: the slot holds 0x55. A second word from input 1 to dest 2 sees io_in_ready[1]=0 until out_ready[2] rises, then loads with no bubble.
- Drain and load: a continuous stream 0x1,0x2,0x3 from input 3 to dest 0 with out_ready[0]=1. Required: one word per cycle on out0, latency 1, no idle gap.
- Reset mid-operation: with slots 0 and 2 valid, assert reset for 1 cycle. Required: all io_out_valid=0, bits=0, src=0 and io_in_ready=0 during reset. Normal grants resume the next cycle.
- Illegal destination, PORTS=3: input 1 sends dest=3. Required: io_in_ready[1]=1 and no io_out_valid change.
